// File: rtl/div_ctrl_if.sv
// div_ctrl_if: handshake/data bundle between the EX stage and the divide sequencer.
//   master modport : EX stage side (drives the request, reads the result)
//   slave modport  : div_ctrl side
// Signals:
//   start        request; held high while a DIV/DIVU sits in EX
//   signed_div   1 = DIV (two's complement), 0 = DIVU
//   opdata1      dividend (rs)
//   opdata2      divisor (rt)
//   annul        cancel the operation in flight
//   result_o     {remainder, quotient}, registered
//   ready_o      one-cycle result-valid pulse, registered
//   stall_req_o  combinational pipeline hold request
interface div_ctrl_if;
    logic        start;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        annul;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stall_req_o;

    modport master (
        output start, signed_div, opdata1, opdata2, annul,
        input  result_o, ready_o, stall_req_o
    );

    modport slave (
        input  start, signed_div, opdata1, opdata2, annul,
        output result_o, ready_o, stall_req_o
    );
endinterface

// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle 32-bit integer divide sequencer (DIV/DIVU) for the EX stage.
// Runs a 32-step restoring division and holds the pipeline through stall_req_o
// until the {remainder, quotient} result is presented for one cycle.
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset
//   bus   div_ctrl_if.slave: start, signed_div, opdata1, opdata2, annul in;
//         result_o (64), ready_o, stall_req_o out
// Optional build macro:
//   DIV_EARLY_EXIT_EN  when defined, a nonzero divide whose |dividend| < |divisor|
//                      finishes after two cycles with quotient 0 and the
//                      original dividend as remainder.
module div_ctrl (
    input  logic      clk,
    input  logic      rst,
    div_ctrl_if.slave bus
);

    typedef enum logic [1:0] {FREE, DIVZERO, ON, END} state_t;

    state_t      state, state_nxt;
    logic [5:0]  cnt, cnt_nxt;
    logic        ready_q;
    logic [63:0] result_q;
    logic [63:0] fin_nxt;
    logic        capture;
    logic        step;

    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] shifted;
    logic        ge;
    logic [31:0] rem_step;
    logic [31:0] quo_step;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    // datapath registers (not reset: only meaningful after a capture)
    logic [31:0] rem_p0;
    logic [31:0] quo_p0;
    logic [31:0] dvs_p0;
    logic        neg_q_p0;
    logic        neg_r_p0;
`ifdef DIV_EARLY_EXIT_EN
    logic        early_p0;
`endif

    function automatic logic [31:0] abs32(input logic signed [31:0] v);
        logic signed [31:0] n;
        n = -v;
        return v[31] ? unsigned'(n) : unsigned'(v);
    endfunction

    function automatic logic [31:0] neg32(input logic [31:0] v);
        logic signed [31:0] s;
        s = -$signed(v);
        return unsigned'(s);
    endfunction

    assign bus.stall_req_o = bus.start & ~ready_q & ~bus.annul;
    assign bus.ready_o     = ready_q;
    assign bus.result_o    = result_q;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        step      = 1'b0;
        fin_nxt   = 64'h0;

        a_mag = bus.signed_div ? abs32($signed(bus.opdata1)) : bus.opdata1;
        b_mag = bus.signed_div ? abs32($signed(bus.opdata2)) : bus.opdata2;

        // One restoring step: the dividend shifts out of quo_p0 into the
        // partial remainder while quotient bits shift in from the bottom.
        // A non-negative difference is exactly shifted >= divisor.
        shifted  = {rem_p0, quo_p0[31]};
        ge       = (shifted >= {1'b0, dvs_p0});
        rem_step = ge ? 32'(shifted - {1'b0, dvs_p0}) : shifted[31:0];
        quo_step = {quo_p0[30:0], ge};

        q_fix = neg_q_p0 ? neg32(quo_step) : quo_step;
        r_fix = neg_r_p0 ? neg32(rem_step) : rem_step;

        case (state)
            FREE: begin
                if (bus.start && !bus.annul) begin
                    capture = 1'b1;
                    cnt_nxt = 6'd0;
                    state_nxt = (bus.opdata2 == 32'h0) ? DIVZERO : ON;
                end
            end
            DIVZERO: begin
                if (bus.annul || !bus.start) begin
                    state_nxt = FREE;
                end else begin
                    state_nxt = END;
                    fin_nxt   = 64'h0;
                end
            end
            ON: begin
                if (bus.annul || !bus.start) begin
                    state_nxt = FREE;
`ifdef DIV_EARLY_EXIT_EN
                end else if (early_p0) begin
                    // quo_p0 still holds |dividend|; re-applying its sign
                    // restores the original dividend as the remainder.
                    state_nxt = END;
                    fin_nxt   = {(neg_r_p0 ? neg32(quo_p0) : quo_p0), 32'h0};
`endif
                end else begin
                    step    = 1'b1;
                    cnt_nxt = cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        state_nxt = END;
                        fin_nxt   = {r_fix, q_fix};
                    end
                end
            end
            END: begin
                state_nxt = FREE;
            end
            default: begin
                state_nxt = FREE;
            end
        endcase
    end

    // control state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FREE;
            cnt      <= 6'd0;
            ready_q  <= 1'b0;
            result_q <= 64'h0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            ready_q  <= (state_nxt == END);
            result_q <= fin_nxt;
        end
    end

    // operand capture / iteration datapath
    always_ff @(posedge clk) begin
        if (capture) begin
            rem_p0   <= 32'h0;
            quo_p0   <= a_mag;
            dvs_p0   <= b_mag;
            neg_q_p0 <= bus.signed_div & (bus.opdata1[31] ^ bus.opdata2[31]);
            neg_r_p0 <= bus.signed_div & bus.opdata1[31];
`ifdef DIV_EARLY_EXIT_EN
            early_p0 <= (a_mag < b_mag);
`endif
        end else if (step) begin
            rem_p0 <= rem_step;
            quo_p0 <= quo_step;
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
module tb_div_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

`ifdef DIV_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    always #5 clk = ~clk;

    div_ctrl_if bus ();

    div_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference: truncating integer division on wide signed integers.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sd);
        longint sa, sb, q, r;
        if (b == 32'h0) return 64'h0;
        sa = sd ? longint'($signed(a)) : longint'(a);
        sb = sd ? longint'($signed(b)) : longint'(b);
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input logic sd);
        longint sa, sb;
        if (b == 32'h0) return 2;
        sa = sd ? longint'($signed(a)) : longint'(a);
        sb = sd ? longint'($signed(b)) : longint'(b);
        if (sa < 0) sa = -sa;
        if (sb < 0) sb = -sb;
        if (EARLY && (sa < sb)) return 2;
        return 33;
    endfunction

    // Drives one request starting in the cycle after the next rising edge and
    // measures ready latency, result and stall cycles (cycles 0..ready).
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sd, input bit keep,
                          output int lat, output logic [63:0] res, output int stalls,
                          output logic post_rdy, output logic [63:0] post_res);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.signed_div = sd; bus.opdata1 = a; bus.opdata2 = b; bus.annul = 1'b0;
        lat = -1; res = 64'h0; stalls = 0; post_rdy = 1'b0; post_res = 64'h0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.stall_req_o) stalls++;
            if (bus.ready_o) begin
                lat = c;
                res = bus.result_o;
                break;
            end
            @(posedge clk); #1;
        end
        if (!keep) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            @(negedge clk);
            post_rdy = bus.ready_o;
            post_res = bus.result_o;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.signed_div = 1'b0; bus.opdata1 = 32'h0; bus.opdata2 = 32'h0; bus.annul = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", bus.ready_o); end
        n_cmp++; if (bus.result_o !== 64'h0) begin n_bad++; $display("FAIL reset_result: got %h want 0", bus.result_o); end
        n_cmp++; if (bus.stall_req_o !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", bus.stall_req_o); end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] ta [8] = '{32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'd5, 32'd3, 32'hFFFF_FFFF, 32'd7, 32'h8000_0000};
        logic [31:0] tb [8] = '{32'd7, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd10, 32'd1, 32'hFFFF_FFFE, 32'd1};
        logic        ts [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int lat, stalls;
        logic [63:0] res, pres, exp_res;
        logic prdy;
        for (int i = 0; i < 8; i++) begin
            exp_res = ref_div(ta[i], tb[i], ts[i]);
            do_div(ta[i], tb[i], ts[i], 1'b0, lat, res, stalls, prdy, pres);
            n_cmp++; if (res !== exp_res) begin n_bad++; $display("FAIL dir_result[%0d]: got %h want %h", i, res, exp_res); end
            n_cmp++; if (lat != ref_lat(ta[i], tb[i], ts[i])) begin n_bad++; $display("FAIL dir_latency[%0d]: got %0d want %0d", i, lat, ref_lat(ta[i], tb[i], ts[i])); end
            n_cmp++; if (stalls != ref_lat(ta[i], tb[i], ts[i])) begin n_bad++; $display("FAIL dir_stall_cycles[%0d]: got %0d want %0d", i, stalls, ref_lat(ta[i], tb[i], ts[i])); end
            n_cmp++; if ({prdy, pres} !== 65'h0) begin n_bad++; $display("FAIL dir_free_after[%0d]: got %b/%h want 0/0", i, prdy, pres); end
        end
        // spot values that do not rely on the model
        do_div(32'd100, 32'd7, 1'b0, 1'b0, lat, res, stalls, prdy, pres);
        n_cmp++; if (res !== {32'd2, 32'd14}) begin n_bad++; $display("FAIL divu_100_7: got %h want %h", res, {32'd2, 32'd14}); end
        do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, lat, res, stalls, prdy, pres);
        n_cmp++; if (res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin n_bad++; $display("FAIL div_m7_2: got %h want ffffffff_fffffffd", res); end
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, lat, res, stalls, prdy, pres);
        n_cmp++; if (res !== {32'h0, 32'h8000_0000}) begin n_bad++; $display("FAIL div_overflow: got %h want 00000000_80000000", res); end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic sd;
        int kind, lat, stalls;
        logic [63:0] res, pres, exp_res;
        logic prdy;
        for (int i = 0; i < 30; i++) begin
            kind = $urandom_range(0, 3);
            a = $urandom; b = $urandom;
            sd = 1'($urandom_range(0, 1));
            case (kind)
                0: b = 32'h0;
                1: begin
                    b = $urandom_range(1, 20);
                    if ($urandom_range(0, 1) == 1) b = ~b + 32'd1;
                end
                2: begin
                    b = $urandom_range(100, 1000);
                    a = $urandom_range(0, 99);
                end
                default: ;
            endcase
            exp_res = ref_div(a, b, sd);
            do_div(a, b, sd, 1'b0, lat, res, stalls, prdy, pres);
            n_cmp++; if (res !== exp_res) begin n_bad++; $display("FAIL rnd_result[%0d] %h/%h s=%b: got %h want %h", i, a, b, sd, res, exp_res); end
            n_cmp++; if (lat != ref_lat(a, b, sd)) begin n_bad++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", i, lat, ref_lat(a, b, sd)); end
            n_cmp++; if (stalls != ref_lat(a, b, sd)) begin n_bad++; $display("FAIL rnd_stall_cycles[%0d]: got %0d want %0d", i, stalls, ref_lat(a, b, sd)); end
            n_cmp++; if ({prdy, pres} !== 65'h0) begin n_bad++; $display("FAIL rnd_free_after[%0d]: got %b/%h want 0/0", i, prdy, pres); end
        end
    endtask

    // Starts DIVU 1000/3 and runs it through cycles 0..9 watching for a stray ready.
    task automatic start_long(output bit saw_rdy);
        saw_rdy = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.signed_div = 1'b0; bus.opdata1 = 32'd1000; bus.opdata2 = 32'd3; bus.annul = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.ready_o) saw_rdy = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_annul();
        bit saw;
        int lat, stalls;
        logic [63:0] res, pres;
        logic prdy;
        start_long(saw);
        bus.annul = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.stall_req_o !== 1'b0) begin n_bad++; $display("FAIL annul_stall: got %b want 0", bus.stall_req_o); end
        n_cmp++; if (saw || bus.ready_o !== 1'b0) begin n_bad++; $display("FAIL annul_no_ready: got %b want 0", saw | bus.ready_o); end
        do_div(32'd9, 32'd3, 1'b0, 1'b0, lat, res, stalls, prdy, pres);
        n_cmp++; if (lat != 33) begin n_bad++; $display("FAIL annul_next_latency: got %0d want 33", lat); end
        n_cmp++; if (res !== {32'd0, 32'd3}) begin n_bad++; $display("FAIL annul_next_result: got %h want %h", res, {32'd0, 32'd3}); end
    endtask

    task automatic test_reset_mid();
        bit saw;
        int lat, stalls;
        logic [63:0] res, pres;
        logic prdy;
        start_long(saw);
        rst = 1'b1;
        #1;
        n_cmp++; if ({bus.ready_o, bus.result_o} !== 65'h0) begin n_bad++; $display("FAIL rst_mid_outputs: got %b/%h want 0/0", bus.ready_o, bus.result_o); end
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        do_div(32'd9, 32'd3, 1'b0, 1'b0, lat, res, stalls, prdy, pres);
        n_cmp++; if (lat != 33 || res !== {32'd0, 32'd3}) begin n_bad++; $display("FAIL rst_mid_next: got lat %0d res %h want 33 %h", lat, res, {32'd0, 32'd3}); end
        // asynchronous reset in the middle of the ready cycle
        do_div(32'd100, 32'd7, 1'b0, 1'b1, lat, res, stalls, prdy, pres);
        n_cmp++; if (res !== {32'd2, 32'd14}) begin n_bad++; $display("FAIL rst_ready_pre: got %h want %h", res, {32'd2, 32'd14}); end
        #1 rst = 1'b1;
        #1;
        n_cmp++; if (bus.ready_o !== 1'b0) begin n_bad++; $display("FAIL rst_async_ready: got %b want 0", bus.ready_o); end
        n_cmp++; if (bus.result_o !== 64'h0) begin n_bad++; $display("FAIL rst_async_result: got %h want 0", bus.result_o); end
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, st1, st2;
        logic [63:0] r1, r2, pres;
        logic prdy;
        logic [31:0] a1, b1, a2, b2;
        time t1, t2;
        a1 = $urandom; b1 = $urandom_range(1, 5000);
        a2 = $urandom; b2 = $urandom_range(1, 70000) | 32'h1000_0000;
        do_div(a1, b1, 1'b1, 1'b1, lat1, r1, st1, prdy, pres);
        t1 = $time;
        do_div(a2, b2, 1'b1, 1'b0, lat2, r2, st2, prdy, pres);
        t2 = $time - 10;
        n_cmp++; if (r1 !== ref_div(a1, b1, 1'b1)) begin n_bad++; $display("FAIL b2b_first: got %h want %h", r1, ref_div(a1, b1, 1'b1)); end
        n_cmp++; if (r2 !== ref_div(a2, b2, 1'b1)) begin n_bad++; $display("FAIL b2b_second: got %h want %h", r2, ref_div(a2, b2, 1'b1)); end
        n_cmp++; if ((t2 - t1) != 340 || lat1 < 0 || lat2 < 0) begin n_bad++; $display("FAIL b2b_spacing: got %0d want 340 (time units)", t2 - t1); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_annul();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
